pe_sparse_mc: RTL and testbench

- Next-generation processing element for the systolic convolution array.
- Holds a per-channel, per-tap weight bank (NUM_CH × N) and an N-deep feature shift register.
- Each accepted feature is multiply-accumulated into NUM_CH partial sums, skipping zero weights so that sparse filters take fewer cycles.
- After a configured number of features, it adds the upstream partial sums and presents the result downstream on a valid/ready handshake.

---
 rtl/pe_pkg.sv | 43 ++++
 rtl/pe_weight_bank.sv | 51 +++++
 rtl/pe_sparse_mc.sv | 210 +++++++++++++++++++++
 tb/tb_pe_sparse_mc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and saturating arithmetic for the sparse PE
// Contents: FSM state enum, wide calculation width, signed saturation limits
//           and a saturating add clamped to a caller-supplied accumulator width.
package pe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_MAC  = 2'd2,
      ST_OUT  = 2'd3
   } pe_state_t;

   // Sums are formed at this width so that two in-range ACC_WIDTH operands
   // can never overflow before clamping.
   localparam int CALC_W = 64;

   function automatic logic signed [CALC_W-1:0] sat_max(input int unsigned width);
      logic signed [CALC_W-1:0] one;
      one = 1;
      return (one <<< (width - 1)) - one;
   endfunction

   function automatic logic signed [CALC_W-1:0] sat_min(input int unsigned width);
      return ~sat_max(width);
   endfunction

   function automatic logic signed [CALC_W-1:0] sat_add(
      input logic signed [CALC_W-1:0] a,
      input logic signed [CALC_W-1:0] b,
      input int unsigned              width
   );
      logic signed [CALC_W-1:0] s;
      s = a + b;
      if (s > sat_max(width)) begin
         return sat_max(width);
      end
      if (s < sat_min(width)) begin
         return sat_min(width);
      end
      return s;
   endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// rtl/pe_weight_bank.sv - NUM_CH x N signed weight register file
// Ports: clk_i, rst_n_i (sync active-low clear); we_i/wr_ch_i/wr_tap_i/wr_data_i
//        single write port; rd_tap_i shared read tap; rd_data_o packed weights
//        (channel 0 in LSBs); nz_mask_o[ch] = weight[ch][rd_tap_i] != 0.
module pe_weight_bank #(
   parameter int F_WIDTH = 8,
   parameter int N       = 3,
   parameter int NUM_CH  = 2,
   parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int TAP_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        we_i,
   input  logic [CH_W-1:0]             wr_ch_i,
   input  logic [TAP_W-1:0]            wr_tap_i,
   input  logic signed [F_WIDTH-1:0]   wr_data_i,
   input  logic [TAP_W-1:0]            rd_tap_i,
   output logic [NUM_CH*F_WIDTH-1:0]   rd_data_o,
   output logic [NUM_CH-1:0]           nz_mask_o
);

   logic signed [F_WIDTH-1:0] w_q [NUM_CH][N];

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         for (int t = 0; t < N; t++) begin
            if (!rst_n_i) begin
               w_q[c][t] <= '0;
            end else if (we_i && wr_ch_i == CH_W'(c) && wr_tap_i == TAP_W'(t)) begin
               w_q[c][t] <= wr_data_i;
            end
         end
      end
   end

   // Out-of-range taps read as zero, so they never trigger a MAC.
   always_comb begin
      rd_data_o = '0;
      nz_mask_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int t = 0; t < N; t++) begin
            if (rd_tap_i == TAP_W'(t)) begin
               rd_data_o[c*F_WIDTH +: F_WIDTH] = w_q[c][t];
               nz_mask_o[c] = (w_q[c][t] != '0);
            end
         end
      end
   end

endmodule

// File: rtl/pe_sparse_mc.sv
// rtl/pe_sparse_mc.sv - multi-channel zero-skipping MAC processing element
// Ports: clk_i, rst_n_i (sync active-low); w_load_i/w_ch_i/w_tap_i/w_data_i
//        weight writes (IDLE only); cfg_len_i/start_i window control;
//        feat_valid_i/feat_i/f_sel_i/feat_ready_o feature input; top_psum_i
//        upstream sums; out_valid_o/out_ready_i/out_psum_o result; busy_o.
module pe_sparse_mc
   import pe_pkg::*;
#(
   parameter int I_WIDTH   = 8,
   parameter int F_WIDTH   = 8,
   parameter int N         = 3,
   parameter int NUM_CH    = 2,
   parameter int ACC_WIDTH = I_WIDTH + F_WIDTH + 4,
   parameter int LEN_WIDTH = 8,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int TAP_W     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          w_load_i,
   input  logic [CH_W-1:0]               w_ch_i,
   input  logic [TAP_W-1:0]              w_tap_i,
   input  logic signed [F_WIDTH-1:0]     w_data_i,
   input  logic [LEN_WIDTH-1:0]          cfg_len_i,
   input  logic                          start_i,
   input  logic                          feat_valid_i,
   input  logic signed [I_WIDTH-1:0]     feat_i,
   input  logic [TAP_W-1:0]              f_sel_i,
   output logic                          feat_ready_o,
   input  logic [NUM_CH*ACC_WIDTH-1:0]   top_psum_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_CH*ACC_WIDTH-1:0]   out_psum_o,
   output logic                          busy_o
);

   localparam int PROD_W = I_WIDTH + F_WIDTH;

   pe_state_t                  state_q;
   logic signed [I_WIDTH-1:0]  freg_q [N];
   logic signed [ACC_WIDTH-1:0] acc_q [NUM_CH];
   logic signed [ACC_WIDTH-1:0] acc_nx [NUM_CH];
   logic signed [ACC_WIDTH-1:0] top_ch [NUM_CH];
   logic [LEN_WIDTH-1:0]       len_q, cnt_q, cnt_inc;
   logic [TAP_W-1:0]           sel_q, rd_tap;
   logic [NUM_CH-1:0]          mask_q, mask_rest, mac_onehot, nz_mask;
   logic signed [I_WIDTH-1:0]  op_q, op_nx;
   logic signed [F_WIDTH-1:0]  w_sel;
   logic signed [PROD_W-1:0]   prod;
   logic [NUM_CH*F_WIDTH-1:0]  rd_w;
   logic [NUM_CH*ACC_WIDTH-1:0] out_nx;
   logic                       ready_q, valid_q, busy_q, accept;

   // While a feature is being MACed the bank must keep reading its latched tap.
   assign rd_tap = (state_q == ST_MAC) ? sel_q : f_sel_i;

   pe_weight_bank #(
      .F_WIDTH (F_WIDTH),
      .N       (N),
      .NUM_CH  (NUM_CH),
      .CH_W    (CH_W),
      .TAP_W   (TAP_W)
   ) u_bank (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .we_i      (w_load_i && (state_q == ST_IDLE)),
      .wr_ch_i   (w_ch_i),
      .wr_tap_i  (w_tap_i),
      .wr_data_i (w_data_i),
      .rd_tap_i  (rd_tap),
      .rd_data_o (rd_w),
      .nz_mask_o (nz_mask)
   );

   assign accept  = ready_q && feat_valid_i;
   assign cnt_inc = cnt_q + LEN_WIDTH'(1);

   // Operand is the tap selected after this cycle's shift: tap 0 is feat_i,
   // tap k is what currently sits in freg_q[k-1].
   always_comb begin
      op_nx = feat_i;
      for (int k = 1; k < N; k++) begin
         if (f_sel_i == TAP_W'(k)) begin
            op_nx = freg_q[k-1];
         end
      end
   end

   // Lowest set bit of the pending mask picks this cycle's channel.
   assign mac_onehot = mask_q & ~(mask_q - NUM_CH'(1));
   assign mask_rest  = mask_q & (mask_q - NUM_CH'(1));

   always_comb begin
      w_sel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (mac_onehot[c]) begin
            w_sel = rd_w[c*F_WIDTH +: F_WIDTH];
         end
      end
   end

   assign prod = $signed({{F_WIDTH{op_q[I_WIDTH-1]}}, op_q})
               * $signed({{I_WIDTH{w_sel[F_WIDTH-1]}}, w_sel});

   always_comb begin
      out_nx = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         top_ch[c] = $signed(top_psum_i[c*ACC_WIDTH +: ACC_WIDTH]);
         acc_nx[c] = acc_q[c];
         if (state_q == ST_MAC && mac_onehot[c]) begin
            acc_nx[c] = ACC_WIDTH'(sat_add({{(CALC_W-ACC_WIDTH){acc_q[c][ACC_WIDTH-1]}}, acc_q[c]},
                                           {{(CALC_W-PROD_W){prod[PROD_W-1]}}, prod},
                                           ACC_WIDTH));
         end
         // Built from acc_nx so the final MAC lands in the result the same cycle.
         out_nx[c*ACC_WIDTH +: ACC_WIDTH] =
            ACC_WIDTH'(sat_add({{(CALC_W-ACC_WIDTH){acc_nx[c][ACC_WIDTH-1]}}, acc_nx[c]},
                               {{(CALC_W-ACC_WIDTH){top_ch[c][ACC_WIDTH-1]}}, top_ch[c]},
                               ACC_WIDTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         sel_q      <= '0;
         mask_q     <= '0;
         op_q       <= '0;
         out_psum_o <= '0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         for (int k = 0; k < N; k++) freg_q[k] <= '0;
         for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  len_q  <= cfg_len_i;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
                  if (cfg_len_i != '0) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end else begin
                     // Empty window: accumulators are zero, result is the upstream sum.
                     state_q    <= ST_OUT;
                     valid_q    <= 1'b1;
                     out_psum_o <= top_psum_i;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  freg_q[0] <= feat_i;
                  for (int k = 1; k < N; k++) freg_q[k] <= freg_q[k-1];
                  op_q   <= op_nx;
                  sel_q  <= f_sel_i;
                  mask_q <= nz_mask;
                  cnt_q  <= cnt_inc;
                  if (nz_mask != '0) begin
                     state_q <= ST_MAC;
                     ready_q <= 1'b0;
                  end else if (cnt_inc == len_q) begin
                     state_q    <= ST_OUT;
                     ready_q    <= 1'b0;
                     valid_q    <= 1'b1;
                     out_psum_o <= out_nx;
                  end
               end
            end
            ST_MAC: begin
               for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_nx[c];
               mask_q <= mask_rest;
               if (mask_rest == '0) begin
                  if (cnt_q == len_q) begin
                     state_q    <= ST_OUT;
                     valid_q    <= 1'b1;
                     out_psum_o <= out_nx;
                  end else begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (out_ready_i) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign feat_ready_o = ready_q;
   assign out_valid_o  = valid_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_pe_sparse_mc.sv
// tb/tb_pe_sparse_mc.sv - directed self-checking bench for pe_sparse_mc
module tb_pe_sparse_mc;

   localparam int IW = 8, FW = 8, NT = 3, NC = 2, AW = 20, LW = 8;
   localparam longint MAXV = 524287;
   localparam longint MINV = -524288;

   logic              clk = 1'b0;
   logic              rst_n_i, w_load_i, start_i, feat_valid_i, out_ready_i;
   logic [0:0]        w_ch_i;
   logic [1:0]        w_tap_i, f_sel_i;
   logic [FW-1:0]     w_data_i;
   logic [LW-1:0]     cfg_len_i;
   logic [IW-1:0]     feat_i;
   logic [NC*AW-1:0]  top_psum_i, out_psum_o;
   logic              feat_ready_o, out_valid_o, busy_o;

   always #5 clk = ~clk;

   pe_sparse_mc dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n_i),
      .w_load_i     (w_load_i),
      .w_ch_i       (w_ch_i),
      .w_tap_i      (w_tap_i),
      .w_data_i     (w_data_i),
      .cfg_len_i    (cfg_len_i),
      .start_i      (start_i),
      .feat_valid_i (feat_valid_i),
      .feat_i       (feat_i),
      .f_sel_i      (f_sel_i),
      .feat_ready_o (feat_ready_o),
      .top_psum_i   (top_psum_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_psum_o   (out_psum_o),
      .busy_o       (busy_o)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [63:0] dut_ch(input int c);
      logic signed [AW-1:0] v;
      v = out_psum_o[c*AW +: AW];
      return v;
   endfunction

   // Reference model: weights, feature history, expected window result.
   longint w_m [NC][NT];
   longint fr_m [NT];
   longint exp_ch [NC];
   int     exp_cyc;
   int     fq [$];
   int     sq [$];

   function automatic longint sat(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   task automatic load_q(input int n, input int v0, input int step, input int s);
      fq.delete();
      sq.delete();
      for (int i = 0; i < n; i++) begin
         fq.push_back(v0 + i * step);
         sq.push_back(s);
      end
   endtask

   task automatic model_run(input longint top0, input longint top1);
      longint acc [NC];
      for (int c = 0; c < NC; c++) acc[c] = 0;
      exp_cyc = 0;
      foreach (fq[i]) begin
         for (int k = NT - 1; k > 0; k--) fr_m[k] = fr_m[k-1];
         fr_m[0] = fq[i];
         exp_cyc++;
         for (int c = 0; c < NC; c++) begin
            if (w_m[c][sq[i]] != 0) begin
               acc[c] = sat(acc[c] + fr_m[sq[i]] * w_m[c][sq[i]]);
               exp_cyc++;
            end
         end
      end
      exp_ch[0] = sat(acc[0] + top0);
      exp_ch[1] = sat(acc[1] + top1);
   endtask

   task automatic wr_w(input int c, input int t, input longint v);
      @(negedge clk);
      w_load_i = 1'b1;
      w_ch_i   = 1'(c);
      w_tap_i  = 2'(t);
      w_data_i = FW'(v);
      @(negedge clk);
      w_load_i = 1'b0;
      w_m[c][t] = v;
   endtask

   longint cap0, cap1;
   int     cyc, rdy_cnt;

   // Runs one window from the feature queues; hold = cycles of downstream stall.
   task automatic run_window(input longint top0, input longint top1, input int hold);
      int idx;
      model_run(top0, top1);
      @(negedge clk);
      start_i    = 1'b1;
      cfg_len_i  = LW'(fq.size());
      top_psum_i = {AW'(top1), AW'(top0)};
      @(negedge clk);
      start_i = 1'b0;
      cyc     = 0;
      rdy_cnt = 0;
      idx     = 0;
      while (!out_valid_o && cyc < 2000) begin
         if (feat_ready_o) rdy_cnt++;
         if (idx < fq.size()) begin
            feat_valid_i = 1'b1;
            feat_i       = IW'(fq[idx]);
            f_sel_i      = 2'(sq[idx]);
            if (feat_ready_o) idx++;
         end else begin
            feat_valid_i = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      feat_valid_i = 1'b0;
      chk("proc_cycles", cyc, exp_cyc);
      cap0 = dut_ch(0);
      cap1 = dut_ch(1);
      for (int h = 0; h < hold; h++) begin
         out_ready_i = 1'b0;
         start_i     = (h == 1);
         cfg_len_i   = 8'd3;
         // Weight writes outside IDLE must be dropped.
         w_load_i    = (h == 2);
         w_ch_i      = 1'b0;
         w_tap_i     = 2'd2;
         w_data_i    = 8'd50;
         @(negedge clk);
         chk("hold_valid", out_valid_o, 1);
         chk("hold_ch0", dut_ch(0), cap0);
         chk("hold_ch1", dut_ch(1), cap1);
         chk("hold_busy", busy_o, 1);
      end
      start_i     = 1'b0;
      w_load_i    = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("idle_valid", out_valid_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_ready", feat_ready_o, 0);
   endtask

   // Continuous comparison of every presented result against the model.
   always @(negedge clk) begin
      if (rst_n_i && out_valid_o) begin
         chk("cmp_ch0", dut_ch(0), exp_ch[0]);
         chk("cmp_ch1", dut_ch(1), exp_ch[1]);
         chk("cmp_busy", busy_o, 1);
      end
   end

   initial begin
      rst_n_i = 1'b0; w_load_i = 1'b0; start_i = 1'b0; feat_valid_i = 1'b0;
      out_ready_i = 1'b0; w_ch_i = '0; w_tap_i = '0; f_sel_i = '0;
      w_data_i = '0; cfg_len_i = '0; feat_i = '0; top_psum_i = '0;
      for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) w_m[c][t] = 0;
      for (int k = 0; k < NT; k++) fr_m[k] = 0;
      exp_ch[0] = 0; exp_ch[1] = 0;
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;
      chk("rst_ready", feat_ready_o, 0);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_psum", out_psum_o, 0);

      // Dense: all weights 2, features 1,2,3 at tap 0.
      for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) wr_w(c, t, 2);
      load_q(3, 1, 1, 0);
      run_window(10, 20, 0);
      chk("dense_ch0", cap0, 22);
      chk("dense_ch1", cap1, 32);
      chk("dense_cycles", cyc, 9);

      // Sparse with backpressure; tap 1 sees the previous feature (3 then 4).
      wr_w(0, 1, 3);
      wr_w(1, 1, 0);
      load_q(2, 4, 1, 1);
      run_window(6, 100, 5);
      chk("sparse_ch0", cap0, 27);
      chk("sparse_ch1", cap1, 100);
      chk("sparse_cycles", cyc, 4);

      // All-zero column: four back-to-back accepts, result is the upstream sum.
      wr_w(0, 2, 0);
      wr_w(1, 2, 0);
      load_q(4, 7, 1, 2);
      run_window(-3, 15, 0);
      chk("zero_ch0", cap0, -3);
      chk("zero_ch1", cap1, 15);
      chk("zero_cycles", cyc, 4);
      chk("zero_ready_run", rdy_cnt, 4);

      // Positive saturation: 40 x 127*127 exceeds the 20-bit range.
      wr_w(0, 0, 127);
      wr_w(1, 0, 127);
      load_q(40, 127, 0, 0);
      run_window(-5, 0, 0);
      chk("satp_ch0", cap0, 524282);
      chk("satp_ch1", cap1, 524287);
      chk("satp_cycles", cyc, 120);

      // Negative saturation.
      wr_w(0, 0, -128);
      wr_w(1, 0, -128);
      run_window(0, 7, 0);
      chk("satn_ch0", cap0, -524288);
      chk("satn_ch1", cap1, -524281);

      // Reset in the middle of a MAC sequence.
      @(negedge clk);
      start_i   = 1'b1;
      cfg_len_i = 8'd5;
      @(negedge clk);
      start_i      = 1'b0;
      feat_valid_i = 1'b1;
      feat_i       = 8'd1;
      f_sel_i      = 2'd0;
      @(negedge clk);
      feat_valid_i = 1'b0;
      chk("mac_busy", busy_o, 1);
      chk("mac_ready", feat_ready_o, 0);
      rst_n_i = 1'b0;
      @(negedge clk);
      rst_n_i = 1'b1;
      chk("mrst_ready", feat_ready_o, 0);
      chk("mrst_valid", out_valid_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_psum", out_psum_o, 0);
      for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) w_m[c][t] = 0;
      for (int k = 0; k < NT; k++) fr_m[k] = 0;

      // Empty window goes straight to OUT.
      load_q(0, 0, 0, 0);
      run_window(33, -44, 0);
      chk("len0_ch0", cap0, 33);
      chk("len0_ch1", cap1, -44);
      chk("len0_cycles", cyc, 0);

      // Cleared weights: features are skipped and only the upstream sum remains.
      load_q(2, 5, 1, 0);
      run_window(1, 2, 0);
      chk("wclr_ch0", cap0, 1);
      chk("wclr_ch1", cap1, 2);
      chk("wclr_cycles", cyc, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
